// File: rtl/retire_stage_if.sv
// ROB-head / retire-stage bus: oldest-first head window in, retire count and
// registered architectural-map / free-list commit traffic out.
interface retire_stage_if #(
    parameter int N                = 3,
    parameter int PHYS_REG_ID_BITS = 6,
    parameter int ARCH_REG_BITS    = 5
);
    localparam int NUM_SCALAR_BITS = $clog2(N + 1);

    typedef struct packed {
        logic [ARCH_REG_BITS-1:0]    dest_reg_idx;
        logic [PHYS_REG_ID_BITS-1:0] T_new;
        logic [PHYS_REG_ID_BITS-1:0] T_old;
        logic                        halt;
        logic                        mispredict;
        logic [31:0]                 target_pc;
    } rob_packet_t;

    rob_packet_t [N-1:0]                    rob_outputs;
    logic [NUM_SCALAR_BITS-1:0]             rob_outputs_valid;
    logic [N-1:0]                           rob_complete;
    logic [NUM_SCALAR_BITS-1:0]             num_retiring;

    logic [N-1:0]                           arch_map_we;
    logic [N-1:0][ARCH_REG_BITS-1:0]        arch_map_idx;
    logic [N-1:0][PHYS_REG_ID_BITS-1:0]     arch_map_preg;
    logic [N-1:0]                           free_valid;
    logic [N-1:0][PHYS_REG_ID_BITS-1:0]     free_preg;

    // master: the ROB / commit consumers; slave: the retire stage itself
    modport master (
        output rob_outputs, rob_outputs_valid, rob_complete,
        input  num_retiring, arch_map_we, arch_map_idx, arch_map_preg,
               free_valid, free_preg
    );

    modport slave (
        input  rob_outputs, rob_outputs_valid, rob_complete,
        output num_retiring, arch_map_we, arch_map_idx, arch_map_preg,
               free_valid, free_preg
    );
endinterface

// File: rtl/retire_stage.sv
// In-order retire stage: picks how many head ROB entries commit this cycle,
// registers the map/free-list writes, and sequences mispredict recovery and halt.

// Per-slot eligibility and commit qualification.
module retire_lane #(
    parameter int ARCH_REG_BITS = 5
) (
    input  logic                     in_range,
    input  logic                     complete,
    input  logic                     halt,
    input  logic                     mispredict,
    input  logic [ARCH_REG_BITS-1:0] dest_reg_idx,
    input  logic                     retire,
    output logic                     ready,
    output logic                     stop,
    output logic                     commit
);
    assign ready  = in_range & complete;
    assign stop   = halt | mispredict;
    // r0 is hardwired, so it neither claims a new mapping nor frees the old one
    assign commit = retire & (dest_reg_idx != '0);
endmodule

module retire_stage #(
    parameter int N                = 3,
    parameter int PHYS_REG_ID_BITS = 6,
    parameter int ARCH_REG_BITS    = 5,
    parameter int CNT_BITS         = 32
) (
    input  logic                clock,
    input  logic                reset,
    retire_stage_if.slave       bus,
    output logic                flush,
    output logic [31:0]         redirect_pc,
    output logic                halted,
    output logic [CNT_BITS-1:0] retired_count
);
    localparam int NUM_SCALAR_BITS = $clog2(N + 1);

    typedef enum logic [1:0] {RUN, RECOVER, HALTED} state_t;

    state_t                     state;
    logic [N-1:0]               ready;
    logic [N-1:0]               stop;
    logic [N-1:0]               retire;
    logic [N-1:0]               commit;
    logic [NUM_SCALAR_BITS-1:0] k;
    logic                       go;
    logic                       last_halt;
    logic                       last_mp;
    logic [31:0]                last_pc;

    for (genvar i = 0; i < N; i++) begin : g_lane
        retire_lane #(.ARCH_REG_BITS(ARCH_REG_BITS)) u_lane (
            .in_range     (NUM_SCALAR_BITS'(i) < bus.rob_outputs_valid),
            .complete     (bus.rob_complete[i]),
            .halt         (bus.rob_outputs[i].halt),
            .mispredict   (bus.rob_outputs[i].mispredict),
            .dest_reg_idx (bus.rob_outputs[i].dest_reg_idx),
            .retire       (retire[i]),
            .ready        (ready[i]),
            .stop         (stop[i]),
            .commit       (commit[i])
        );
    end

    // Oldest-first scan: the retiring set is a prefix that ends at the first
    // not-ready entry or just after the first halt/mispredict.
    always_comb begin
        retire    = '0;
        k         = '0;
        last_halt = 1'b0;
        last_mp   = 1'b0;
        last_pc   = '0;
        go        = (state == RUN) && !reset;
        for (int i = 0; i < N; i++) begin
            if (go && ready[i]) begin
                retire[i] = 1'b1;
                k         = k + NUM_SCALAR_BITS'(1);
                last_halt = bus.rob_outputs[i].halt;
                last_mp   = bus.rob_outputs[i].mispredict;
                last_pc   = bus.rob_outputs[i].target_pc;
                if (stop[i]) go = 1'b0;
            end else begin
                go = 1'b0;
            end
        end
    end

    assign bus.num_retiring = k;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= RUN;
            bus.arch_map_we   <= '0;
            bus.arch_map_idx  <= '0;
            bus.arch_map_preg <= '0;
            bus.free_valid    <= '0;
            bus.free_preg     <= '0;
            flush             <= 1'b0;
            redirect_pc       <= '0;
            halted            <= 1'b0;
            retired_count     <= '0;
        end else begin
            bus.arch_map_we <= commit;
            bus.free_valid  <= commit;
            for (int j = 0; j < N; j++) begin
                bus.arch_map_idx[j]  <= bus.rob_outputs[j].dest_reg_idx;
                bus.arch_map_preg[j] <= bus.rob_outputs[j].T_new;
                bus.free_preg[j]     <= bus.rob_outputs[j].T_old;
            end
            retired_count <= retired_count + CNT_BITS'(k);
            flush         <= 1'b0;

            case (state)
                RUN: begin
                    // halt outranks a mispredict on the same entry: no redirect
                    if (last_halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (last_mp) begin
                        state       <= RECOVER;
                        flush       <= 1'b1;
                        redirect_pc <= last_pc;
                    end
                end
                RECOVER: state <= RUN;
                HALTED:  state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end
endmodule
